fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage between the 12-bit program counter and the execute/decode logic.
- Each fetch:
  - presents the current PC to a synchronous program ROM;
  - captures the 8-bit word and splits it into a 4-bit opcode and a 4-bit operand;
  - holds the word under a valid/ready handshake;
  - pulses the counter's enable to advance the PC.
- Jump requests from execute drive the counter's load/valueLoad path and flush any in-flight fetch.

Parameters:
- ADDR_W, 12, PC/ROM address width; matches the counter.
- DATA_W, 8, ROM word width. Opcode is the upper DATA_W/2 bits; operand is the lower DATA_W/2 bits.
- ROM_LATENCY, 1, cycles from the rom_en cycle to valid rom_data. Legal range ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  fetch enable; 0 means the stage idles after the current instruction is accepted.
- pc  in  ADDR_W  current PC from the counter output.
- pc_en  out  1  one-cycle increment pulse to the counter's enable.
- pc_load  out  1  one-cycle load pulse to the counter's load.
- pc_load_val  out  ADDR_W  value for the counter's valueLoad; meaningful only while pc_load=1.
- rom_en  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM address; equals pc while rom_en=1.
- rom_data  in  DATA_W  ROM read data.
- instr  out  DATA_W/2  fetched opcode.
- oprnd  out  DATA_W/2  fetched operand.
- fetch_pc  out  ADDR_W  address the held instruction was fetched from.
- instr_valid  out  1  instr/oprnd/fetch_pc are valid.
- instr_ready  in  1  execute accepts the instruction.
- jmp  in  1  jump request, one-cycle pulse.
- jmp_addr  in  ADDR_W  jump target.

Behaviour:
- Reset (synchronous, highest priority, effective at any state including mid-fetch):
  - state=IDLE, wait counter=0;
  - instr, oprnd, fetch_pc = 0;
  - instr_valid, pc_en, pc_load, rom_en = 0; pc_load_val=0.
- Any ROM data in flight during reset is discarded.
- States: IDLE, REQ, WAIT, HOLD, FLUSH.
  - IDLE: all strobes 0. run=1 → REQ.
  - REQ, one cycle:
    - rom_en=1, rom_addr=pc;
    - latch pc into a pending-address register;
    - wait counter ← ROM_LATENCY-1; → WAIT.
  - WAIT:
    - counter≠0: decrement.
    - counter=0: capture rom_data[DATA_W-1:DATA_W/2]→instr, rom_data[DATA_W/2-1:0]→oprnd, pending address→fetch_pc;
    - instr_valid←1; pc_en←1 for exactly the next cycle; → HOLD.
  - HOLD:
    - instr/oprnd/fetch_pc stable while instr_valid=1.
    - instr_valid=1 & instr_ready=1 = accept; instr_valid←0 next cycle.
    - After accept: run=1 → REQ; run=0 → IDLE.
    - instr_ready is ignored while instr_valid=0.
  - FLUSH, one cycle: pc_load=1, pc_load_val=registered jmp_addr; → REQ if run=1, else IDLE.
- Latency and throughput:
  - With REQ in cycle t, instr_valid rises in cycle t+ROM_LATENCY+1.
  - pc_en is high in that same cycle, so the counter holds PC+1 by the next edge.
  - With instr_ready tied high, one instruction is delivered every ROM_LATENCY+2 cycles.
  - The next REQ always sees the incremented PC.
- Jump: jmp=1 in any state other than IDLE, or in IDLE with run=1, takes priority over capture, accept and REQ:
  - register jmp_addr; instr_valid←0; discard any pending ROM result;
  - suppress a capture scheduled in that cycle; → FLUSH.
  - jmp in IDLE with run=0 is still honoured: FLUSH, then IDLE.
- Strobe exclusivity:
  - pc_en and pc_load are never high in the same cycle.
  - A pc_en pulse issued in the cycle jmp arrives is harmless, because pc_load follows and overrides it.
- run deasserted mid-fetch: the current fetch completes and is held until accepted; the stage then goes to IDLE with no further REQ.
- Widths:
  - pc wraps 0xFFF→0x000 in the counter; this stage treats it as an ordinary address.
  - No arithmetic is done on pc here.
- rom_addr is driven combinationally from pc only while rom_en=1; otherwise it is 0.

Test Plan:
- Reset, then run=1, pc=0x000, ROM[0]=0xA5, ROM_LATENCY=1, instr_ready=1 → rom_en in cycle 1; instr=0xA, oprnd=0x5, fetch_pc=0x000, instr_valid=1 and pc_en=1 in cycle 3; next REQ in cycle 4 with pc=0x001.
- Back-pressure: instr_ready=0 for 5 cycles after valid → instr/oprnd held, exactly one pc_en pulse, no REQ. Ready=1 → accept, then REQ with the incremented pc.
- Jump during WAIT: jmp=1, jmp_addr=0x3C0 → no capture, instr_valid stays 0, pc_load=1 with pc_load_val=0x3C0 next cycle. Next REQ has rom_addr=0x3C0.
- Jump coincident with a valid instruction (HOLD, ready=1) → instruction not consumed past this cycle, instr_valid=0 next cycle, FLUSH, no pc_en/pc_load overlap.
- Wrap and latency: pc=0xFFF, ROM_LATENCY=3 → instr_valid 4 cycles after REQ, fetch_pc=0xFFF, following REQ at 0x000.
- Synchronous reset asserted in WAIT, and run dropped during HOLD → all outputs 0 at the next edge with no capture. With run dropped, after accept the stage sits in IDLE with rom_en=0 indefinitely.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: reads one ROM word per fetch at the current PC,
// splits it into opcode/operand, holds it under a valid/ready handshake and
// drives the program counter's increment and load strobes. A jump always
// wins: it flushes the fetch in flight and reloads the counter.
module fetch_stage #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [ADDR_W-1:0]   pc,
  output logic                pc_en,
  output logic                pc_load,
  output logic [ADDR_W-1:0]   pc_load_val,
  output logic                rom_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic [DATA_W/2-1:0] instr,
  output logic [DATA_W/2-1:0] oprnd,
  output logic [ADDR_W-1:0]   fetch_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                jmp,
  input  logic [ADDR_W-1:0]   jmp_addr
);

  localparam int HALF_W = DATA_W / 2;
  localparam int CNT_W  = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ROM_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   pend_q, pend_d;
  logic [HALF_W-1:0]   instr_q, instr_d;
  logic [HALF_W-1:0]   oprnd_q, oprnd_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                valid_q, valid_d;
  logic                pc_en_q, pc_en_d;
  logic                pc_load_q, pc_load_d;
  logic [ADDR_W-1:0]   pc_load_val_q, pc_load_val_d;
  logic                rom_en_q, rom_en_d;

  // Next-state and registered-output decode; a jump pre-empts every other action.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    instr_d       = instr_q;
    oprnd_d       = oprnd_q;
    fetch_pc_d    = fetch_pc_q;
    valid_d       = valid_q;
    pc_en_d       = 1'b0;
    pc_load_d     = 1'b0;
    pc_load_val_d = '0;
    rom_en_d      = 1'b0;

    if (jmp) begin
      state_d       = ST_FLUSH;
      valid_d       = 1'b0;
      pc_load_d     = 1'b1;
      pc_load_val_d = jmp_addr;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_d  = ST_REQ;
            rom_en_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          pend_d  = pc;
          cnt_d   = LAT_M1;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            instr_d    = rom_data[DATA_W-1:HALF_W];
            oprnd_d    = rom_data[HALF_W-1:0];
            fetch_pc_d = pend_q;
            valid_d    = 1'b1;
            pc_en_d    = 1'b1;
            state_d    = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (valid_q && instr_ready) begin
            valid_d = 1'b0;
            if (run) begin
              state_d  = ST_REQ;
              rom_en_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_FLUSH: begin
          if (run) begin
            state_d  = ST_REQ;
            rom_en_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pend_q        <= '0;
      instr_q       <= '0;
      oprnd_q       <= '0;
      fetch_pc_q    <= '0;
      valid_q       <= 1'b0;
      pc_en_q       <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_load_val_q <= '0;
      rom_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      instr_q       <= instr_d;
      oprnd_q       <= oprnd_d;
      fetch_pc_q    <= fetch_pc_d;
      valid_q       <= valid_d;
      pc_en_q       <= pc_en_d;
      pc_load_q     <= pc_load_d;
      pc_load_val_q <= pc_load_val_d;
      rom_en_q      <= rom_en_d;
    end
  end

  assign pc_en       = pc_en_q;
  assign pc_load     = pc_load_q;
  assign pc_load_val = pc_load_val_q;
  assign rom_en      = rom_en_q;
  // The ROM address follows the counter directly, gated to zero outside REQ.
  assign rom_addr    = rom_en_q ? pc : '0;
  assign instr       = instr_q;
  assign oprnd       = oprnd_q;
  assign fetch_pc    = fetch_pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one instance at ROM latency 1 and one at
// latency 3, each with a behavioural program counter and synchronous ROM.
module tb_fetch_stage;

  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] rom_mem [4096];
  logic [AW-1:0] exp_q [$];

  // ---------------- latency-1 instance ----------------
  logic          reset, run, instr_ready, jmp;
  logic [AW-1:0] pc, jmp_addr, pc_load_val, rom_addr, fetch_pc;
  logic          pc_en, pc_load, rom_en, instr_valid;
  logic [DW-1:0] rom_data, rom_q;
  logic [3:0]    instr, oprnd;

  fetch_stage #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .run(run), .pc(pc), .pc_en(pc_en),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr), .oprnd(oprnd),
    .fetch_pc(fetch_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jmp(jmp), .jmp_addr(jmp_addr)
  );

  // Program counter model for instance 1.
  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_en) pc <= pc + 12'd1;
  end

  // One-cycle synchronous ROM for instance 1.
  always_ff @(posedge clk) begin
    rom_q <= rom_en ? rom_mem[rom_addr] : 8'h00;
  end
  assign rom_data = rom_q;

  // ---------------- latency-3 instance ----------------
  logic          reset3, run3, instr_ready3, jmp3;
  logic [AW-1:0] pc3, jmp_addr3, pc_load_val3, rom_addr3, fetch_pc3;
  logic          pc_en3, pc_load3, rom_en3, instr_valid3;
  logic [DW-1:0] rom_data3, p0, p1, p2;
  logic [3:0]    instr3, oprnd3;

  fetch_stage #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset3), .run(run3), .pc(pc3), .pc_en(pc_en3),
    .pc_load(pc_load3), .pc_load_val(pc_load_val3), .rom_en(rom_en3),
    .rom_addr(rom_addr3), .rom_data(rom_data3), .instr(instr3), .oprnd(oprnd3),
    .fetch_pc(fetch_pc3), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
    .jmp(jmp3), .jmp_addr(jmp_addr3)
  );

  // Program counter model for instance 3.
  always_ff @(posedge clk) begin
    if (reset3) pc3 <= '0;
    else if (pc_load3) pc3 <= pc_load_val3;
    else if (pc_en3) pc3 <= pc3 + 12'd1;
  end

  // Three-cycle pipelined ROM for instance 3.
  always_ff @(posedge clk) begin
    p0 <= rom_en3 ? rom_mem[rom_addr3] : 8'h00;
    p1 <= p0;
    p2 <= p1;
  end
  assign rom_data3 = p2;

  function automatic logic [7:0] rom_word(input logic [AW-1:0] a);
    logic [7:0] w;
    logic [7:0] hi;
    hi = {4'h0, a[11:8]};
    w  = a[7:0] * 8'd37;
    w  = w + hi * 8'd19;
    w  = w + 8'hA5;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected fetch and compare the held instruction with it.
  task automatic check_fetch(input string tag, input logic [3:0] oi,
                             input logic [3:0] oo, input logic [AW-1:0] of);
    logic [AW-1:0] a;
    logic [7:0]    w;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      a = exp_q.pop_front();
      w = rom_word(a);
      chk({tag, "_instr"}, 32'(oi), 32'(w[7:4]));
      chk({tag, "_oprnd"}, 32'(oo), 32'(w[3:0]));
      chk({tag, "_fetch_pc"}, 32'(of), 32'(a));
    end
  endtask

  // pc_en and pc_load must never coincide on either instance.
  always @(negedge clk) begin
    n_assert++;
    assert (!(pc_en && pc_load) && !(pc_en3 && pc_load3)) else begin
      n_fail++;
      $error("FAIL strobe_overlap: observed=1 expected=0");
    end
  end

  initial begin
    int pe_cnt;
    int re_cnt;
    logic [7:0] w1;
    for (int i = 0; i < 4096; i++) rom_mem[i] = rom_word(12'(i));
    w1 = rom_word(12'h001);

    reset = 1'b1; run = 1'b0; instr_ready = 1'b1; jmp = 1'b0; jmp_addr = '0;
    reset3 = 1'b1; run3 = 1'b0; instr_ready3 = 1'b1; jmp3 = 1'b0; jmp_addr3 = '0;
    step(); step(); step();

    // Reset state
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_pc_load_val", 32'(pc_load_val), 32'd0);
    chk("rst_instr", 32'({instr, oprnd}), 32'd0);
    chk("rst_fetch_pc", 32'(fetch_pc), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);

    // First fetch: cycle 0 idle, REQ in cycle 1, valid in cycle 3
    reset = 1'b0; run = 1'b1;
    step();
    chk("c1_rom_en", 32'(rom_en), 32'd1);
    chk("c1_rom_addr", 32'(rom_addr), 32'h000);
    exp_q.push_back(12'h000);
    step();
    chk("c2_rom_en", 32'(rom_en), 32'd0);
    chk("c2_valid", 32'(instr_valid), 32'd0);
    step();
    chk("c3_valid", 32'(instr_valid), 32'd1);
    chk("c3_pc_en", 32'(pc_en), 32'd1);
    chk("c3_instr_lit", 32'({instr, oprnd}), 32'hA5);
    check_fetch("c3", instr, oprnd, fetch_pc);
    step();
    chk("c4_rom_en", 32'(rom_en), 32'd1);
    chk("c4_rom_addr", 32'(rom_addr), 32'h001);
    chk("c4_valid", 32'(instr_valid), 32'd0);
    chk("c4_pc_en", 32'(pc_en), 32'd0);
    exp_q.push_back(12'h001);

    // Back-pressure for five cycles
    instr_ready = 1'b0;
    step();
    step();
    chk("bp_valid", 32'(instr_valid), 32'd1);
    check_fetch("bp", instr, oprnd, fetch_pc);
    pe_cnt = int'(pc_en);
    re_cnt = int'(rom_en);
    for (int k = 1; k < 5; k++) begin
      step();
      chk("bp_hold_valid", 32'(instr_valid), 32'd1);
      chk("bp_hold_word", 32'({instr, oprnd}), 32'(w1));
      pe_cnt += int'(pc_en);
      re_cnt += int'(rom_en);
    end
    chk("bp_pc_en_pulses", 32'(pe_cnt), 32'd1);
    chk("bp_no_req", 32'(re_cnt), 32'd0);
    instr_ready = 1'b1;
    step();
    chk("bp_req_rom_en", 32'(rom_en), 32'd1);
    chk("bp_req_addr", 32'(rom_addr), 32'h002);
    chk("bp_accept_valid", 32'(instr_valid), 32'd0);
    exp_q.push_back(12'h002);

    // Jump during WAIT
    step();
    chk("jw_wait_valid", 32'(instr_valid), 32'd0);
    jmp = 1'b1; jmp_addr = 12'h3C0;
    step();
    jmp = 1'b0;
    chk("jw_valid", 32'(instr_valid), 32'd0);
    chk("jw_pc_load", 32'(pc_load), 32'd1);
    chk("jw_pc_load_val", 32'(pc_load_val), 32'h3C0);
    chk("jw_pc_en", 32'(pc_en), 32'd0);
    exp_q.delete();
    step();
    chk("jw_req_rom_en", 32'(rom_en), 32'd1);
    chk("jw_req_addr", 32'(rom_addr), 32'h3C0);
    chk("jw_req_pc_load", 32'(pc_load), 32'd0);
    chk("jw_req_valid", 32'(instr_valid), 32'd0);
    exp_q.push_back(12'h3C0);
    step();
    step();
    chk("jt_valid", 32'(instr_valid), 32'd1);
    chk("jt_pc_en", 32'(pc_en), 32'd1);
    check_fetch("jt", instr, oprnd, fetch_pc);

    // Jump coincident with a valid instruction and ready
    jmp = 1'b1; jmp_addr = 12'h123;
    step();
    jmp = 1'b0;
    chk("jh_valid", 32'(instr_valid), 32'd0);
    chk("jh_pc_load", 32'(pc_load), 32'd1);
    chk("jh_pc_load_val", 32'(pc_load_val), 32'h123);
    chk("jh_pc_en", 32'(pc_en), 32'd0);
    chk("jh_rom_en", 32'(rom_en), 32'd0);
    step();
    chk("jh_req_addr", 32'(rom_addr), 32'h123);
    chk("jh_req_rom_en", 32'(rom_en), 32'd1);
    exp_q.push_back(12'h123);

    // Synchronous reset in WAIT
    step();
    reset = 1'b1;
    step();
    chk("rw_valid", 32'(instr_valid), 32'd0);
    chk("rw_pc_en", 32'(pc_en), 32'd0);
    chk("rw_rom_en", 32'(rom_en), 32'd0);
    chk("rw_word", 32'({instr, oprnd}), 32'd0);
    chk("rw_fetch_pc", 32'(fetch_pc), 32'd0);
    exp_q.delete();
    reset = 1'b0;

    // run dropped mid-fetch: complete, hold, accept, then idle
    step();
    chk("rd_req_addr", 32'(rom_addr), 32'h000);
    chk("rd_req_rom_en", 32'(rom_en), 32'd1);
    exp_q.push_back(12'h000);
    step();
    run = 1'b0;
    step();
    chk("rd_valid", 32'(instr_valid), 32'd1);
    check_fetch("rd", instr, oprnd, fetch_pc);
    instr_ready = 1'b0;
    step();
    chk("rd_hold_valid", 32'(instr_valid), 32'd1);
    chk("rd_hold_rom_en", 32'(rom_en), 32'd0);
    instr_ready = 1'b1;
    step();
    chk("rd_acc_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rd_idle_rom_en", 32'(rom_en), 32'd0);
      chk("rd_idle_valid", 32'(instr_valid), 32'd0);
      chk("rd_idle_pc_en", 32'(pc_en), 32'd0);
    end

    // Jump in IDLE with run=0: flush, then back to idle
    jmp = 1'b1; jmp_addr = 12'h055;
    step();
    jmp = 1'b0;
    chk("ji_pc_load", 32'(pc_load), 32'd1);
    chk("ji_pc_load_val", 32'(pc_load_val), 32'h055);
    step();
    chk("ji_after_pc_load", 32'(pc_load), 32'd0);
    chk("ji_after_rom_en", 32'(rom_en), 32'd0);
    step();
    chk("ji_idle_rom_en", 32'(rom_en), 32'd0);

    // Latency 3 and PC wrap at 0xFFF
    reset3 = 1'b0; run3 = 1'b1; jmp3 = 1'b1; jmp_addr3 = 12'hFFF;
    step();
    jmp3 = 1'b0;
    chk("w_pc_load", 32'(pc_load3), 32'd1);
    chk("w_pc_load_val", 32'(pc_load_val3), 32'hFFF);
    chk("w_flush_rom_en", 32'(rom_en3), 32'd0);
    step();
    chk("w_req_rom_en", 32'(rom_en3), 32'd1);
    chk("w_req_addr", 32'(rom_addr3), 32'hFFF);
    exp_q.push_back(12'hFFF);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("w_wait_valid", 32'(instr_valid3), 32'd0);
    end
    step();
    chk("w_valid", 32'(instr_valid3), 32'd1);
    chk("w_pc_en", 32'(pc_en3), 32'd1);
    check_fetch("w", instr3, oprnd3, fetch_pc3);
    step();
    chk("w_next_rom_en", 32'(rom_en3), 32'd1);
    chk("w_next_addr", 32'(rom_addr3), 32'h000);
    run3 = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
